add_result_stage: RTL

//  Registered output stage directly downstream of the 32-bit carry-select adder.

---
 rtl/add_result_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/add_result_stage.sv
// add_result_stage: registered adder output stage with flag derivation, result FIFO and event counters
module add_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = WIDTH + 4;
  typedef enum logic {NORMAL, FULL} mode_t;
  mode_t            mode_q, mode_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] res_count_q, res_count_d, ovf_count_q, ovf_count_d;
  logic             push, pop, f_zero, f_neg, f_ovf;
  logic [EW-1:0]    entry, head;
  // Flags are derived from the adder inputs and stored alongside the sum
  always_comb begin
    f_zero = ~|in_sum;
    f_neg  = in_sum[WIDTH-1];
    f_ovf  = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    entry  = {in_sum, in_cout, f_zero, f_neg, f_ovf};
    head   = mem_q[rd_ptr_q];
  end
  assign in_ready  = !rst && (mode_q != FULL);
  assign out_valid = !rst && (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_sum, out_cout, out_zero, out_neg, out_ovf} = head;
  assign res_count = res_count_q;
  assign ovf_count = ovf_count_q;
  // Next-state for storage, pointers, occupancy, mode and counters
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d       = occ_q + OW'(push) - OW'(pop);
    mode_d      = (mode_q == FULL) ? (pop ? NORMAL : FULL)
                : (push && !pop && occ_q == OW'(DEPTH - 1)) ? FULL : NORMAL;
    res_count_d = res_count_q + CNT_W'(push);
    ovf_count_d = (push && f_ovf && !(&ovf_count_q)) ? ovf_count_q + CNT_W'(1) : ovf_count_q;
  end
  // State registers; reset discards all buffered entries
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      mode_q      <= NORMAL;
      res_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      mode_q      <= mode_d;
      res_count_q <= res_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end
endmodule
